// File: rtl/plru_update_stage_if.sv
// Request, response and LRU-array bus of the PLRU update stage.
// req_way_valid exists only when PLRU_INVALID_FIRST_EN is defined.
interface plru_update_stage_if #(
    parameter int unsigned s_index = 3,
    parameter int unsigned s_way   = 2
);
    localparam int unsigned num_ways = 2 ** s_way;

    logic                  req_valid;
    logic                  req_ready;
    logic [s_index-1:0]    req_index;
    logic [s_way-1:0]      req_way;
    logic                  req_touch;
`ifdef PLRU_INVALID_FIRST_EN
    logic [num_ways-1:0]   req_way_valid;
`endif
    logic                  resp_valid;
    logic                  resp_ready;
    logic [s_index-1:0]    resp_index;
    logic [s_way-1:0]      resp_victim;
    logic                  arr_read;
    logic [s_index-1:0]    arr_rindex;
    logic [num_ways-2:0]   arr_dataout;
    logic                  arr_load;
    logic [s_index-1:0]    arr_windex;
    logic [num_ways-2:0]   arr_datain;

    // master is the requester plus the LRU array; slave is the stage itself.
    modport master (
`ifdef PLRU_INVALID_FIRST_EN
        output req_way_valid,
`endif
        output req_valid, req_index, req_way, req_touch, resp_ready, arr_dataout,
        input  req_ready, resp_valid, resp_index, resp_victim,
        input  arr_read, arr_rindex, arr_load, arr_windex, arr_datain
    );

    modport slave (
`ifdef PLRU_INVALID_FIRST_EN
        input  req_way_valid,
`endif
        input  req_valid, req_index, req_way, req_touch, resp_ready, arr_dataout,
        output req_ready, resp_valid, resp_index, resp_victim,
        output arr_read, arr_rindex, arr_load, arr_windex, arr_datain
    );
endinterface

// File: rtl/plru_update_stage.sv
// Tree pseudo-LRU read-modify-write stage in front of the LRU register array.
// Define PLRU_INVALID_FIRST_EN to prefer the lowest-numbered invalid way as victim.
module plru_update_stage #(
    parameter int unsigned s_index = 3,
    parameter int unsigned s_way   = 2
) (
    input  logic                clk,
    input  logic                rst,
    plru_update_stage_if.slave  bus
);
    localparam int unsigned num_ways = 2 ** s_way;
    localparam int unsigned node_w   = s_way + 1;

    logic                s1_valid;
    logic [s_index-1:0]  s1_index;
    logic [s_way-1:0]    s1_way;
    logic                s1_touch;
`ifdef PLRU_INVALID_FIRST_EN
    logic [num_ways-1:0] s1_way_valid;
`endif

    logic                accept;
    logic                fire;
    logic [2*num_ways-1:0] tree_cur;
    logic [node_w-1:0]   walk;
    logic [s_way-1:0]    plru_victim;
    logic [s_way-1:0]    victim;
    logic [num_ways-2:0] upd_bits;

    assign bus.req_ready = !s1_valid || bus.resp_ready;
    // Gating with rst drops an in-flight request without touching the array.
    assign accept = bus.req_valid && bus.req_ready && !rst;
    assign fire   = s1_valid && bus.resp_ready && !rst;

    assign bus.arr_read    = accept;
    assign bus.arr_rindex  = bus.req_index;
    assign bus.arr_load    = fire && s1_touch;
    assign bus.arr_windex  = s1_index;
    assign bus.arr_datain  = upd_bits;
    assign bus.resp_valid  = s1_valid;
    assign bus.resp_index  = s1_index;
    assign bus.resp_victim = victim;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_index <= '0;
            s1_way   <= '0;
            s1_touch <= 1'b0;
`ifdef PLRU_INVALID_FIRST_EN
            s1_way_valid <= '1;
`endif
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_index <= bus.req_index;
            s1_way   <= bus.req_way;
            s1_touch <= bus.req_touch;
`ifdef PLRU_INVALID_FIRST_EN
            s1_way_valid <= bus.req_way_valid;
`endif
        end else if (bus.resp_ready) begin
            s1_valid <= 1'b0;
        end
    end

    // Victim walk over the heap; the array holds its output while S1 stalls.
    always_comb begin
        tree_cur    = {{(num_ways + 1){1'b0}}, bus.arr_dataout};
        walk        = '0;
        plru_victim = '0;
        for (int lvl = 0; lvl < int'(s_way); lvl++) begin
            plru_victim = (plru_victim << 1) | s_way'(tree_cur[walk]);
            walk        = (walk << 1) + node_w'(1) + node_w'(tree_cur[walk]);
        end
    end

    // Node n (heap 1-based n+1) lies on the path to way w when it is an ancestor of leaf {1,w}.
    for (genvar n = 0; n < int'(num_ways) - 1; n++) begin : g_node
        localparam int unsigned depth = $clog2(n + 2) - 1;
        logic [node_w-1:0] anc;
        assign anc         = {1'b1, s1_way} >> (s_way - depth);
        assign upd_bits[n] = (anc == node_w'(n + 1)) ? !s1_way[s_way-1-depth]
                                                     : bus.arr_dataout[n];
    end

`ifdef PLRU_INVALID_FIRST_EN
    always_comb begin
        victim = plru_victim;
        for (int i = int'(num_ways) - 1; i >= 0; i--) begin
            if (!s1_way_valid[i]) victim = s_way'(i);
        end
    end
`else
    assign victim = plru_victim;
`endif
endmodule
